// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if - handshake bundle between four requesters, the
// round-robin arbiter and a single downstream sink.
//   in_valid/in_data_0..3/in_ready : requester side valid/ready handshake
//   out_valid/out_data/out_src/out_ready : registered output stage to sink
// modport master : requesters + sink (environment side)
// modport slave  : the arbiter itself
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data_0;
    logic [WIDTH-1:0] in_data_1;
    logic [WIDTH-1:0] in_data_2;
    logic [WIDTH-1:0] in_data_3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_ready;

    modport master (
        output in_valid, in_data_0, in_data_1, in_data_2, in_data_3, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data_0, in_data_1, in_data_2, in_data_3, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter - round-robin arbitration of four requesters onto one
// shared 4:1 mux feeding a single registered output stage.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : rr_mux_arbiter_if.slave (requester handshakes + output stage)
// The output stage drains and refills on the same edge, so a continuously
// ready sink sees one word per cycle.
module rr_mux_arbiter #(
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    rr_mux_arbiter_if.slave bus
);
    logic [1:0]       r_ptr;        // last granted requester
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_src;

    logic [1:0]       w_grant;
    logic             w_load;
    logic [WIDTH-1:0] w_mux;

    // Search starts one past the last grant; the 2-bit add wraps naturally.
    // The first hit wins, so later hits are ignored via w_found.
    always_comb begin
        logic [1:0] idx;
        logic       w_found;
        idx     = '0;
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = r_ptr + 2'(k);
            if (!w_found && bus.in_valid[idx]) begin
                w_grant = idx;
                w_found = 1'b1;
            end
        end
    end

    // rst_n gates the load so no handshake completes during reset.
    assign w_load = rst_n && (!r_out_valid || bus.out_ready) && (bus.in_valid != 4'b0000);

    always_comb begin
        unique case (w_grant)
            2'd0:    w_mux = bus.in_data_0;
            2'd1:    w_mux = bus.in_data_1;
            2'd2:    w_mux = bus.in_data_2;
            default: w_mux = bus.in_data_3;
        endcase
    end

    always_comb begin
        bus.in_ready = 4'b0000;
        if (w_load) bus.in_ready[w_grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_ptr       <= 2'd3;    // requester 0 has first priority
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_src   <= w_grant;
            r_ptr       <= w_grant;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;    // data/src keep stale values
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter - directed scoreboard bench for rr_mux_arbiter.
// Stimulus pushes the hand-computed {src,data} of every accepted word; a
// monitor pops and compares whenever the output stage hands a word over.
module tb_rr_mux_arbiter;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] sb[$];

    rr_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

    rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a word transfers on the next edge when out_valid && out_ready.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {26'd0, bus.out_src, bus.out_data}, 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_src", {30'd0, bus.out_src}, {30'd0, e[5:4]});
                    chk("out_data", {28'd0, bus.out_data}, {28'd0, e[3:0]});
                end
            end
        end
    end

    // Called at posedge+1; drives one cycle and checks in_ready combinationally.
    task automatic step(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy,
                        input logic [1:0] esrc, input logic [3:0] edata);
        bus.in_valid  = v;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", {28'd0, bus.in_ready}, {28'd0, exp_rdy});
        if (exp_rdy != 4'b0000) sb.push_back({esrc, edata});
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_data_0 = 4'hA;
        bus.in_data_1 = 4'hB;
        bus.in_data_2 = 4'hC;
        bus.in_data_3 = 4'hD;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset held two cycles with all requesters valid
        @(posedge clk); #1;
        chk("rst_in_ready", {28'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {28'd0, bus.out_data}, 32'd0);
        chk("rst_out_src", {30'd0, bus.out_src}, 32'd0);
        chk("rst_in_ready2", {28'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;

        // Full contention: 0,1,2,3,0
        step(4'b1111, 1'b1, 4'b0001, 2'd0, 4'hA);
        step(4'b1111, 1'b1, 4'b0010, 2'd1, 4'hB);
        step(4'b1111, 1'b1, 4'b0100, 2'd2, 4'hC);
        step(4'b1111, 1'b1, 4'b1000, 2'd3, 4'hD);
        step(4'b1111, 1'b1, 4'b0001, 2'd0, 4'hA);

        // Backpressure: word A from src 0 held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step(4'b0110, 1'b0, 4'b0000, 2'd0, 4'h0);
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_data", {28'd0, bus.out_data}, 32'hA);
            chk("stall_src", {30'd0, bus.out_src}, 32'd0);
        end
        // Drain + refill on the same edge: next after 0 is 1
        step(4'b0110, 1'b1, 4'b0010, 2'd1, 4'hB);
        step(4'b0110, 1'b1, 4'b0100, 2'd2, 4'hC);

        // Wrap-around
        step(4'b1000, 1'b1, 4'b1000, 2'd3, 4'hD);
        step(4'b1001, 1'b1, 4'b0001, 2'd0, 4'hA);
        step(4'b1001, 1'b1, 4'b1000, 2'd3, 4'hD);

        // Sparse single pulse from requester 2
        bus.in_data_2 = 4'h5;
        step(4'b0100, 1'b1, 4'b0100, 2'd2, 4'h5);
        chk("pulse_valid_hi", {31'd0, bus.out_valid}, 32'd1);
        step(4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0);
        chk("pulse_valid_lo", {31'd0, bus.out_valid}, 32'd0);
        bus.in_data_2 = 4'hC;

        // Reset mid-stall; ptr=2 so requester 0 is found after 3
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 4'hA);
        step(4'b1111, 1'b0, 4'b0000, 2'd0, 4'h0);
        chk("midstall_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        sb.delete();    // held word is discarded by reset
        #1;
        chk("midrst_in_ready", {28'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        rst_n = 1'b1;
        step(4'b1111, 1'b1, 4'b0001, 2'd0, 4'hA);
        step(4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0);
        step(4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Shares one 4:1 data-path multiplexer between four requesters using round-robin arbitration.
- Each requester presents data with a valid/ready handshake.
- The arbiter drives the mux select, registers the selected word into a single output stage, and reports which source won.
- It sits upstream of any single-consumer sink that needs fair access for four producers.

Parameters:
- WIDTH, 4, data width of each requester word and of out_data.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  4  bit i = requester i has a word on in_data_i
- in_data_0  input  WIDTH  requester 0 data
- in_data_1  input  WIDTH  requester 1 data
- in_data_2  input  WIDTH  requester 2 data
- in_data_3  input  WIDTH  requester 3 data
- in_ready  output  4  bit i = word from requester i is accepted this cycle
- out_valid  output  1  out_data/out_src hold a valid word
- out_data  output  WIDTH  registered selected word
- out_src  output  2  index of the requester that supplied out_data
- out_ready  input  1  sink accepts the output word this cycle

Behaviour:
- One clock; reset is synchronous and active-low: clk, rst_n.
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out_data=0, out_src=0.
  - Last-grant pointer = 3, so requester 0 has first priority.
  - in_ready=0 while rst_n=0.
  - Reset mid-transfer discards any held word; no handshake completes in that cycle.
- Load condition: load = (!out_valid || out_ready) && (in_valid != 0). Computed combinationally each cycle.
- Grant: first i with in_valid[i]=1, searching from (ptr+1) mod 4 upward with wrap-around. grant is a 2-bit index and drives the 4:1 mux select.
- in_ready[i] = load && (grant == i). At most one bit is set. in_ready depends combinationally on in_valid and out_ready; requesters must not make in_valid depend on in_ready.
- On a rising edge with load=1:
  - out_data <= in_data_grant, out_src <= grant, out_valid <= 1, ptr <= grant.
- On a rising edge with load=0:
  - If out_valid && out_ready, out_valid <= 0; out_data and out_src hold their stale values.
  - Otherwise all state holds.
- Stall: while out_valid=1 and out_ready=0, out_data, out_src and out_valid are stable, in_ready=0, and ptr is unchanged.
- Latency: a word accepted at edge N appears on out_data after edge N; minimum 1 cycle.
- Throughput: 1 word/cycle when out_ready is held high (drain and refill in the same edge).
- Fairness: with all four requesters continuously valid, grants cycle 0,1,2,3,0,… Any requester waits at most 3 accepted words before being served.
- Single requester: it is granted every cycle it is valid, regardless of ptr.
- in_valid dropping while not granted: no effect on state.
- Requester protocol: in_data_i must be stable while in_valid[i]=1 and in_ready[i]=0. Not checked by the block.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=4'b1111 → out_valid=0, out_data=0, out_src=0, in_ready=0. After release, the first grant is requester 0.
- Full contention: out_ready=1, in_valid=4'b1111, in_data_i=4'hA+i → in_ready walks 0001,0010,0100,1000,0001. out_src sequence is 0,1,2,3,0 and out_data is A,B,C,D,A, each one cycle after acceptance.
- Backpressure: one word held, out_ready=0 for 3 cycles with in_valid=4'b0110 → out_data/out_src stable and in_ready=0. When out_ready rises, the drain and the refill from the next requester in round-robin order occur on the same edge.
- Wrap-around: after a grant to 3, in_valid=4'b1001 → requester 0 is granted next. After that grant to 0, requester 3 is granted.
- Sparse/idle: single pulse in_valid=4'b0100, in_data_2=4'h5, out_ready=1 → out_valid high for exactly 1 cycle with out_data=5, out_src=2, then out_valid=0.
- Reset mid-stall: out_valid=1 with out_ready=0, assert rst_n=0 for 1 cycle → out_valid=0 and ptr=3. The next grant with in_valid=4'b1111 goes to requester 0.
